// File: rtl/mem_wait_responder.sv
// Word-wide memory responder: one request at a time, fixed wait states, then a
// response held until the CPU takes it. Flags misaligned and out-of-range accesses.
module mem_wait_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               we_p0;
  logic               err_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [31:0]        wdata_p0;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               enter_resp;
  logic               mem_we;
  logic               sel_we;
  logic               sel_err;
  logic [IDX_W-1:0]   sel_idx;
  logic [31:0]        sel_wdata;

  // Full 32-bit word-index compare so huge addresses never alias into the array.
  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  assign accept     = (state == ST_IDLE) && req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd0));

  // With zero wait states the commit happens on the accept edge, before the latch is loaded.
  assign sel_we    = (state == ST_IDLE) ? req_we                    : we_p0;
  assign sel_err   = (state == ST_IDLE) ? addr_err(req_addr)        : err_p0;
  assign sel_idx   = (state == ST_IDLE) ? req_addr[IDX_W+1:2]       : idx_p0;
  assign sel_wdata = (state == ST_IDLE) ? req_wdata                 : wdata_p0;

  assign mem_we = enter_resp && sel_we && !sel_err && !reset;

  // Stage p0: request latch, loaded only on accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      err_p0   <= addr_err(req_addr);
      idx_p0   <= req_addr[IDX_W+1:2];
      wdata_p0 <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[sel_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (enter_resp) begin
        rsp_err   <= sel_err;
        rsp_rdata <= (sel_we || sel_err) ? 32'd0 : mem[sel_idx];
      end
      case (state)
        ST_IDLE: begin
          // First IDLE cycle after a response is a bubble with req_ready low.
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a WAIT_CYCLES=2 instance for function and
// error cases, and a WAIT_CYCLES=0 instance for minimum latency and request spacing.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        z_req_valid, z_req_we, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  mem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_ready(z_req_ready),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0F0F_0F0F;
  endtask

  // lat = edge (counting the accept edge as 0) at which the CPU samples rsp_valid high
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_bubble"}, 32'(req_ready), 32'd0);
    tick();
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int lat;
    start_req(tag, we, addr, wdata);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    finish_rsp(tag);
  endtask

  initial begin
    int lat;
    int k;
    int acc [3];
    logic seen;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
    z_rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    do_txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_txn("ld10", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_txn("ld12_mis", 1'b0, 32'h12, 32'd0, 32'd0, 1'b1);
    do_txn("ld10_again", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_txn("st_mis", 1'b1, 32'h11, 32'h5555_5555, 32'd0, 1'b1);
    do_txn("ld10_after_mis", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_txn("stFC", 1'b1, 32'hFC, 32'h0BAD_F00D, 32'd0, 1'b0);
    do_txn("st100_oor", 1'b1, 32'h100, 32'hFFFF_FFFF, 32'd0, 1'b1);
    do_txn("ldFC", 1'b0, 32'hFC, 32'd0, 32'h0BAD_F00D, 1'b0);
    do_txn("ld100_oor", 1'b0, 32'h100, 32'd0, 32'd0, 1'b1);
    do_txn("stF0", 1'b1, 32'hF0, 32'h1111_0000, 32'd0, 1'b0);
    do_txn("st_wrap", 1'b1, 32'hFFFF_FFF0, 32'h2222_0000, 32'd0, 1'b1);
    do_txn("ldF0", 1'b0, 32'hF0, 32'd0, 32'h1111_0000, 1'b0);
    do_txn("ld0_mis3", 1'b0, 32'h3, 32'd0, 32'd0, 1'b1);

    // response held for 5 cycles while a competing store is presented
    start_req("hold", 1'b0, 32'h10, 32'd0);
    wait_rsp(lat);
    chk("hold_lat", 32'(lat), 32'd3);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_vld", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp("hold");
    do_txn("ld10_post_hold", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // reset while a store waits: store is dropped
    do_txn("st20_pre", 1'b1, 32'h20, 32'hCAFE_0020, 32'd0, 1'b0);
    start_req("st20_rst", 1'b1, 32'h20, 32'h1234_5678);
    chk("st20_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    do_txn("ld20", 1'b0, 32'h20, 32'd0, 32'hCAFE_0020, 1'b0);

    // reset while a store sits in RESP: store already committed
    start_req("st24_rst", 1'b1, 32'h24, 32'h5A5A_0024);
    wait_rsp(lat);
    chk("st24_lat", 32'(lat), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstr_rdata", rsp_rdata, 32'd0);
    do_txn("ld24", 1'b0, 32'h24, 32'd0, 32'h5A5A_0024, 1'b0);

    // zero-wait instance: store, then continuous loads
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hA5A5_A5A5;
    chk("z_ready", 32'(z_req_ready), 32'd1);
    tick();
    z_req_valid = 1'b0;
    chk("z_st_vld", 32'(z_rsp_valid), 32'd1);
    chk("z_st_err", 32'(z_rsp_err), 32'd0);
    z_rsp_ready = 1'b1;
    tick();
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h8;
    k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      seen = z_req_valid && z_req_ready;
      if (seen) begin
        if (k < 3) acc[k] = cyc;
        k++;
      end
      tick();
      if (seen) begin
        chk("z_ld_vld", 32'(z_rsp_valid), 32'd1);
        chk("z_ld_rdata", z_rsp_rdata, 32'hA5A5_A5A5);
      end
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    chk("z_accepts", 32'(k >= 3), 32'd1);
    if (k >= 3) begin
      chk("z_space1", 32'(acc[1] - acc[0]), 32'd3);
      chk("z_space2", 32'(acc[2] - acc[1]), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
